// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and the receive FSM encoding.
package uart_pkg;

    localparam int UART_OVERSAMBLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line synchroniser and 3-vote majority sampler for the UART receive path.
module uart_bit_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    input  logic vote_en,
    input  logic vote_last,
    output logic rx_sync,
    output logic bit_val
);

    logic [1:0] sync_ff;
    logic [2:0] votes;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= 2'b11;
            votes   <= 3'b111;
        end else begin
            sync_ff <= {sync_ff[0], rx_in};
            if (vote_en)
                votes <= {votes[1:0], sync_ff[1]};
        end
    end

    assign rx_sync = sync_ff[1];

    // On the third vote the decision is needed in the same cycle, so bypass the register.
    assign bit_val = vote_last ? maj3(votes[1], votes[0], rx_sync)
                               : maj3(votes[2], votes[1], votes[0]);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start detection, LSB-first data capture, optional parity and stop-bit check.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMBLE = UART_OVERSAMBLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx_clk,
    input  logic                 rx_in,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int M  = OVERSAMBLE / 2;
    localparam int TW = $clog2(OVERSAMBLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMBLE - 1);
    localparam logic [TW-1:0] T_V0   = TW'(M - 1);
    localparam logic [TW-1:0] T_V2   = TW'(M + 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    rx_state_t state, state_nx;

    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic                 armed;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_acc;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 par_bad;

    logic rx_sync;
    logic bit_val;
    logic vote_en;
    logic vote_last;
    logic bit_end;
    logic stop_done;
    logic start_det;

    assign vote_en   = Rx_clk && (tick_cnt >= T_V0) && (tick_cnt <= T_V2);
    assign vote_last = Rx_clk && (tick_cnt == T_V2);
    assign bit_end   = Rx_clk && (tick_cnt == T_LAST);
    assign stop_done = vote_last && (state == STOP);
    assign start_det = Rx_clk && (state == IDLE) && !rx_sync && armed;

    uart_bit_sampler u_sampler (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .vote_en   (vote_en),
        .vote_last (vote_last),
        .rx_sync   (rx_sync),
        .bit_val   (bit_val)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_det) state_nx = START;
            START:   if (bit_end) state_nx = bit_val ? IDLE : DATA;
            DATA:    if (bit_end && bit_idx == B_LAST) state_nx = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_nx = STOP;
            STOP:    if (stop_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rx_busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            bit_idx    <= '0;
            armed      <= 1'b0;
            shift_reg  <= '0;
            par_acc    <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            par_bad    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= stop_done;
            if (Rx_clk) begin
                // Counter restarts on every state change and at each bit boundary.
                if (state_nx != state || bit_end || state == IDLE)
                    tick_cnt <= '0;
                else
                    tick_cnt <= tick_cnt + 1'b1;

                case (state)
                    IDLE: begin
                        if (rx_sync)
                            armed <= 1'b1;
                        if (start_det) begin
                            bit_idx   <= '0;
                            par_en_q  <= parity_en;
                            par_odd_q <= parity_odd;
                            par_acc   <= 1'b0;
                            par_bad   <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                            par_acc   <= par_acc ^ bit_val;
                            bit_idx   <= (bit_idx == B_LAST) ? '0 : bit_idx + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (bit_end)
                            par_bad <= bit_val ^ par_acc ^ par_odd_q;
                    end
                    STOP: begin
                        if (stop_done) begin
                            rx_data    <= shift_reg;
                            parity_err <= par_bad;
                            frame_err  <= ~bit_val;
                            // A low stop bit may be a break; wait for the line to go high again.
                            if (!bit_val)
                                armed <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized frames vs. a frame-level model.
module tb_uart_receiver;

    localparam int OS      = 16;
    localparam int DB      = 8;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLK = OS * TICK_DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Rx_clk = 1'b0;
    logic          rx_in = 1'b1;
    logic          parity_en = 1'b0;
    logic          parity_odd = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          parity_err;
    logic          frame_err;
    logic          rx_busy;

    int checks = 0;
    int errors = 0;
    int tdiv = 0;

    // Captured frames as {data, parity_err, frame_err}
    logic [DB+1:0] got[$];

    uart_receiver #(.OVERSAMBLE(OS), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .Rx_clk     (Rx_clk),
        .rx_in      (rx_in),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tdiv   = (tdiv + 1) % TICK_DIV;
            Rx_clk = (tdiv == 0);
        end
    end

    always @(negedge clk)
        if (rx_valid) got.push_back({rx_data, parity_err, frame_err});

    // Reference: what the receiver should report for a frame as it was put on the line.
    function automatic logic [DB+1:0] model(input logic [DB-1:0] d, input logic pen,
                                            input logic podd, input logic pbit, input logic stop);
        logic want_par;
        want_par = (^d) ^ podd;
        return {d, pen && (pbit != want_par), ~stop};
    endfunction

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic pen, input logic pbit, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(stop);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, rx_busy} !== '0) begin
            errors++;
            $display("FAIL reset_in got %h want 0", {rx_data, rx_valid, parity_err, frame_err, rx_busy});
        end
        rst = 1'b0;
        idle_bits(1);
        checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, rx_busy} !== '0) begin
            errors++;
            $display("FAIL reset_idle got %h want 0", {rx_data, rx_valid, parity_err, frame_err, rx_busy});
        end
        got.delete();
    endtask

    task automatic test_8n1;
        logic [DB+1:0] exp;
        parity_en = 1'b0; parity_odd = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        exp = model(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (got.size() != 1) begin
            errors++; $display("FAIL 8n1_count got %0d want 1", got.size());
        end else begin
            checks++;
            if (got[0] !== exp) begin errors++; $display("FAIL 8n1_frame got %h want %h", got[0], exp); end
        end
        got.delete();
    endtask

    task automatic test_parity;
        logic [DB-1:0] d[3]   = '{8'h3C, 8'h3C, 8'h00};
        logic          odd[3] = '{1'b0, 1'b0, 1'b1};
        logic          pb[3]  = '{1'b0, 1'b1, 1'b1};
        logic          perr[3] = '{1'b0, 1'b1, 1'b0};
        logic [DB+1:0] exp;
        for (int k = 0; k < 3; k++) begin
            parity_en = 1'b1; parity_odd = odd[k];
            send_frame(d[k], 1'b1, pb[k], 1'b1);
            idle_bits(1);
            exp = {d[k], perr[k], 1'b0};
            checks++;
            if (got.size() != 1) begin
                errors++; $display("FAIL parity_count case %0d got %0d want 1", k, got.size());
            end else begin
                checks++;
                if (got[0] !== exp) begin errors++; $display("FAIL parity_frame case %0d got %h want %h", k, got[0], exp); end
            end
            got.delete();
        end
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask

    task automatic test_glitch;
        rx_in = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clk);
        rx_in = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b want 1", rx_busy); end
        repeat (80) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b want 0", rx_busy); end
        idle_bits(1);
        checks++;
        if (got.size() != 0) begin errors++; $display("FAIL glitch_valid got %0d frames want 0", got.size()); end
        got.delete();
    endtask

    task automatic test_break;
        logic [DB+1:0] exp;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        exp = model(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got.size() != 1) begin
            errors++; $display("FAIL break_count got %0d want 1", got.size());
        end else begin
            checks++;
            if (got[0] !== exp) begin errors++; $display("FAIL break_frame got %h want %h", got[0], exp); end
        end
        got.delete();
        repeat (30 * BIT_CLK) @(negedge clk);
        checks++;
        if (got.size() != 0) begin errors++; $display("FAIL break_hold got %0d frames want 0", got.size()); end
        got.delete();
        idle_bits(2);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        exp = model(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (got.size() != 1) begin
            errors++; $display("FAIL recover_count got %0d want 1", got.size());
        end else begin
            checks++;
            if (got[0] !== exp) begin errors++; $display("FAIL recover_frame got %h want %h", got[0], exp); end
        end
        got.delete();
    endtask

    task automatic test_back_to_back;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        checks++;
        if (got.size() != 2) begin
            errors++; $display("FAIL b2b_count got %0d want 2", got.size());
        end else begin
            checks++;
            if (got[0] !== {8'hFF, 2'b00}) begin errors++; $display("FAIL b2b_first got %h want %h", got[0], {8'hFF, 2'b00}); end
            checks++;
            if (got[1] !== {8'h01, 2'b00}) begin errors++; $display("FAIL b2b_second got %h want %h", got[1], {8'h01, 2'b00}); end
        end
        got.delete();
    endtask

    task automatic test_reset_mid;
        logic [DB+1:0] exp;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", rx_busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, rx_busy} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got %h want 0", {rx_data, rx_valid, parity_err, frame_err, rx_busy});
        end
        rst = 1'b0;
        idle_bits(2);
        checks++;
        if (got.size() != 0) begin errors++; $display("FAIL rstmid_valid got %0d frames want 0", got.size()); end
        got.delete();
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        exp = model(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (got.size() != 1) begin
            errors++; $display("FAIL rstmid_next_count got %0d want 1", got.size());
        end else begin
            checks++;
            if (got[0] !== exp) begin errors++; $display("FAIL rstmid_next got %h want %h", got[0], exp); end
        end
        got.delete();
    endtask

    task automatic test_random;
        logic [DB-1:0] d;
        logic pen, podd, pbit, stop;
        logic [DB+1:0] exp;
        for (int n = 0; n < 10; n++) begin
            d    = DB'($urandom);
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            pbit = ((^d) ^ podd) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 3) != 0);
            parity_en = pen; parity_odd = podd;
            send_frame(d, pen, pbit, stop);
            idle_bits(1 + int'($urandom_range(0, 1)));
            exp = model(d, pen, podd, pbit, stop);
            checks++;
            if (got.size() != 1) begin
                errors++; $display("FAIL rand_count frame %0d got %0d want 1", n, got.size());
            end else begin
                checks++;
                if (got[0] !== exp) begin errors++; $display("FAIL rand_frame %0d got %h want %h", n, got[0], exp); end
            end
            got.delete();
        end
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
